// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and types for the register file with busy scoreboard
package reg_file_pkg;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 3;
   localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;
   typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
   typedef logic [DEF_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-producer bits with set-over-clear priority and popcount
module rf_scoreboard
   import reg_file_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 0,
   localparam int DEPTH   = 2 ** ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr,
   input  logic [ADDR_W-1:0] clr_addr,
   output logic [DEPTH-1:0]  sb_next,
   output logic [DEPTH-1:0]  sb,
   output logic [ADDR_W:0]   cnt
);
   localparam bit ZR = ZERO_REG != 0;
   logic [DEPTH-1:0] sb_d, sb_q;
   logic [ADDR_W:0]  cnt_d, cnt_q;

   // Clear for a completing write, then set for a newly issued producer so set wins
   always_comb begin
      sb_d = sb_q;
      if (clr && !(ZR && clr_addr == '0)) sb_d[clr_addr] = 1'b0;
      if (set && !(ZR && set_addr == '0)) sb_d[set_addr] = 1'b1;
      cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + {{ADDR_W{1'b0}}, sb_d[i]};
   end

   // Busy bits and their registered population count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_q  <= '0;
         cnt_q <= '0;
      end else begin
         sb_q  <= sb_d;
         cnt_q <= cnt_d;
      end
   end

   assign sb_next = sb_d;
   assign sb      = sb_q;
   assign cnt     = cnt_q;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 1-write/2-read clocked register file with registered reads and busy scoreboard
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1,
   localparam int DEPTH   = 2 ** ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_n,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              oe_n,
   input  logic [ADDR_W-1:0] raddr0,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              rvalid,
   input  logic              busy_set,
   input  logic [ADDR_W-1:0] busy_addr,
   output logic              busy0,
   output logic              busy1,
   output logic [ADDR_W:0]   busy_cnt
);
   localparam bit ZR = ZERO_REG != 0;
   localparam bit BP = BYPASS != 0;

   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata0_d, rdata0_q, rdata1_d, rdata1_q;
   logic              rvalid_d, rvalid_q, busy0_d, busy0_q, busy1_d, busy1_q;
   logic              wr_ok;
   logic [DEPTH-1:0]  sb_next, sb;

   assign wr_ok = !we_n && !(ZR && waddr == '0);

   rf_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .set      (busy_set),
      .set_addr (busy_addr),
      .clr      (!we_n),
      .clr_addr (waddr),
      .sb_next  (sb_next),
      .sb       (sb),
      .cnt      (busy_cnt)
   );

   // Storage update; the dropped zero-register write never reaches the array
   always_comb begin
      mem_d = mem_q;
      if (wr_ok) mem_d[waddr] = wdata;
   end

   // Read ports: zero register first, then same-edge forward, else stored value; hold when idle
   always_comb begin
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      busy0_d  = busy0_q;
      busy1_d  = busy1_q;
      rvalid_d = !oe_n;
      if (!oe_n) begin
         rdata0_d = (ZR && raddr0 == '0) ? '0 : (BP && wr_ok && waddr == raddr0) ? wdata : mem_q[raddr0];
         rdata1_d = (ZR && raddr1 == '0) ? '0 : (BP && wr_ok && waddr == raddr1) ? wdata : mem_q[raddr1];
         busy0_d  = (ZR && raddr0 == '0) ? 1'b0 : BP ? sb_next[raddr0] : sb[raddr0];
         busy1_d  = (ZR && raddr1 == '0) ? 1'b0 : BP ? sb_next[raddr1] : sb[raddr1];
      end
   end

   // Array and output registers, all cleared by the asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         rdata0_q <= '0;
         rdata1_q <= '0;
         rvalid_q <= 1'b0;
         busy0_q  <= 1'b0;
         busy1_q  <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         rvalid_q <= rvalid_d;
         busy0_q  <= busy0_d;
         busy1_q  <= busy1_d;
      end
   end

   assign rdata0 = rdata0_q;
   assign rdata1 = rdata1_q;
   assign rvalid = rvalid_q;
   assign busy0  = busy0_q;
   assign busy1  = busy1_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed checks of three reg_file_sb configurations driven in parallel
module tb_reg_file_sb;
   import reg_file_pkg::*;

   logic      clk = 1'b0, rst_n = 1'b0;
   logic      we_n = 1'b1, oe_n = 1'b1, busy_set = 1'b0;
   reg_addr_t waddr = '0, raddr0 = '0, raddr1 = '0, busy_addr = '0;
   reg_data_t wdata = '0;

   // d: ZERO_REG=0 BYPASS=1, n: BYPASS=0, z: ZERO_REG=1
   reg_data_t d_rd0, d_rd1, n_rd0, n_rd1, z_rd0, z_rd1;
   logic      d_rv, n_rv, z_rv, d_b0, d_b1, n_b0, n_b1, z_b0, z_b1;
   logic [3:0] d_cnt, n_cnt, z_cnt;

   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   reg_file_sb #(.ZERO_REG(0), .BYPASS(1)) u_d (
      .clk(clk), .rst_n(rst_n), .we_n(we_n), .waddr(waddr), .wdata(wdata), .oe_n(oe_n),
      .raddr0(raddr0), .raddr1(raddr1), .rdata0(d_rd0), .rdata1(d_rd1), .rvalid(d_rv),
      .busy_set(busy_set), .busy_addr(busy_addr), .busy0(d_b0), .busy1(d_b1), .busy_cnt(d_cnt));
   reg_file_sb #(.ZERO_REG(0), .BYPASS(0)) u_n (
      .clk(clk), .rst_n(rst_n), .we_n(we_n), .waddr(waddr), .wdata(wdata), .oe_n(oe_n),
      .raddr0(raddr0), .raddr1(raddr1), .rdata0(n_rd0), .rdata1(n_rd1), .rvalid(n_rv),
      .busy_set(busy_set), .busy_addr(busy_addr), .busy0(n_b0), .busy1(n_b1), .busy_cnt(n_cnt));
   reg_file_sb #(.ZERO_REG(1), .BYPASS(1)) u_z (
      .clk(clk), .rst_n(rst_n), .we_n(we_n), .waddr(waddr), .wdata(wdata), .oe_n(oe_n),
      .raddr0(raddr0), .raddr1(raddr1), .rdata0(z_rd0), .rdata1(z_rd1), .rvalid(z_rv),
      .busy_set(busy_set), .busy_addr(busy_addr), .busy0(z_b0), .busy1(z_b1), .busy_cnt(z_cnt));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we_n = 1'b1;
      oe_n = 1'b1;
      busy_set = 1'b0;
   endtask

   task automatic test_reset();
      step();
      step();
      rst_n = 1'b1;
      we_n = 1'b0; waddr = 3'd1; wdata = 16'h1111;
      busy_set = 1'b1; busy_addr = 3'd4;
      oe_n = 1'b0; raddr0 = 3'd1; raddr1 = 3'd1;
      step();
      tests++;
      if (d_rd0 !== 16'h1111 || d_cnt !== 4'd1) begin
         fails++;
         $display("FAIL pre_reset: rdata0=%h busy_cnt=%0d, expected 1111 and 1", d_rd0, d_cnt);
      end
      busy_set = 1'b0; oe_n = 1'b1;
      wdata = 16'hBEEF;
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (d_rd0 !== 16'h0 || d_rd1 !== 16'h0 || d_rv !== 1'b0 || d_cnt !== 4'd0 || z_cnt !== 4'd0) begin
         fails++;
         $display("FAIL async_reset: rdata0=%h rdata1=%h rvalid=%b cnt=%0d zcnt=%0d, expected all 0",
                  d_rd0, d_rd1, d_rv, d_cnt, z_cnt);
      end
      step();
      rst_n = 1'b1;
      idle();
      for (int a = 0; a < 8; a++) begin
         oe_n = 1'b0; raddr0 = 3'(a); raddr1 = 3'(a);
         step();
         tests++;
         if (d_rd0 !== 16'h0 || d_rd1 !== 16'h0 || d_rv !== 1'b1 || n_rd0 !== 16'h0) begin
            fails++;
            $display("FAIL reset_read r%0d: rdata0=%h rdata1=%h rvalid=%b, expected 0000 0000 1",
                     a, d_rd0, d_rd1, d_rv);
         end
      end
      idle();
   endtask

   task automatic test_write_read();
      we_n = 1'b0; waddr = 3'd3; wdata = 16'hA5A5;
      step();
      idle();
      oe_n = 1'b0; raddr0 = 3'd3; raddr1 = 3'd3;
      step();
      tests++;
      if (d_rd0 !== 16'hA5A5 || d_rd1 !== 16'hA5A5 || d_rv !== 1'b1) begin
         fails++;
         $display("FAIL write_read: rdata0=%h rdata1=%h rvalid=%b, expected a5a5 a5a5 1", d_rd0, d_rd1, d_rv);
      end
      idle();
      step();
      tests++;
      if (d_rv !== 1'b0 || d_rd0 !== 16'hA5A5) begin
         fails++;
         $display("FAIL rvalid_drop: rvalid=%b rdata0=%h, expected 0 a5a5", d_rv, d_rd0);
      end
   endtask

   task automatic test_bypass();
      we_n = 1'b0; waddr = 3'd5; wdata = 16'h0055;
      step();
      wdata = 16'h1234;
      oe_n = 1'b0; raddr0 = 3'd5; raddr1 = 3'd5;
      step();
      tests++;
      if (d_rd0 !== 16'h1234 || d_rd1 !== 16'h1234) begin
         fails++;
         $display("FAIL bypass_on: rdata0=%h rdata1=%h, expected 1234 1234", d_rd0, d_rd1);
      end
      tests++;
      if (n_rd0 !== 16'h0055) begin
         fails++;
         $display("FAIL bypass_off: rdata0=%h, expected 0055", n_rd0);
      end
      we_n = 1'b1;
      step();
      tests++;
      if (n_rd0 !== 16'h1234) begin
         fails++;
         $display("FAIL bypass_off_later: rdata0=%h, expected 1234", n_rd0);
      end
      idle();
   endtask

   task automatic test_scoreboard();
      busy_set = 1'b1; busy_addr = 3'd2;
      step();
      busy_addr = 3'd6;
      step();
      busy_set = 1'b0;
      oe_n = 1'b0; raddr0 = 3'd2; raddr1 = 3'd6;
      step();
      tests++;
      if (d_cnt !== 4'd2 || d_b0 !== 1'b1 || d_b1 !== 1'b1) begin
         fails++;
         $display("FAIL sb_mark: cnt=%0d busy0=%b busy1=%b, expected 2 1 1", d_cnt, d_b0, d_b1);
      end
      we_n = 1'b0; waddr = 3'd2; wdata = 16'h2222;
      step();
      tests++;
      if (d_cnt !== 4'd1 || d_b0 !== 1'b0 || d_rd0 !== 16'h2222) begin
         fails++;
         $display("FAIL sb_clear: cnt=%0d busy0=%b rdata0=%h, expected 1 0 2222", d_cnt, d_b0, d_rd0);
      end
      tests++;
      if (n_b0 !== 1'b1 || n_cnt !== 4'd1) begin
         fails++;
         $display("FAIL sb_clear_nobypass: busy0=%b cnt=%0d, expected 1 1", n_b0, n_cnt);
      end
      waddr = 3'd6; wdata = 16'h6666;
      busy_set = 1'b1; busy_addr = 3'd6;
      step();
      tests++;
      if (d_cnt !== 4'd1 || d_b1 !== 1'b1 || d_rd1 !== 16'h6666) begin
         fails++;
         $display("FAIL sb_set_wins: cnt=%0d busy1=%b rdata1=%h, expected 1 1 6666", d_cnt, d_b1, d_rd1);
      end
      idle();
   endtask

   task automatic test_zero_reg();
      we_n = 1'b0; waddr = 3'd0; wdata = 16'hFFFF;
      busy_set = 1'b1; busy_addr = 3'd0;
      oe_n = 1'b0; raddr0 = 3'd0; raddr1 = 3'd6;
      step();
      tests++;
      if (z_rd0 !== 16'h0 || z_b0 !== 1'b0 || z_cnt !== 4'd1 || z_b1 !== 1'b1) begin
         fails++;
         $display("FAIL zero_reg: rdata0=%h busy0=%b cnt=%0d busy1=%b, expected 0000 0 1 1", z_rd0, z_b0, z_cnt, z_b1);
      end
      tests++;
      if (d_rd0 !== 16'hFFFF || d_b0 !== 1'b1 || d_cnt !== 4'd2) begin
         fails++;
         $display("FAIL r0_normal: rdata0=%h busy0=%b cnt=%0d, expected ffff 1 2", d_rd0, d_b0, d_cnt);
      end
      we_n = 1'b1; busy_set = 1'b0;
      step();
      tests++;
      if (z_rd0 !== 16'h0 || d_rd0 !== 16'hFFFF || z_cnt !== 4'd1) begin
         fails++;
         $display("FAIL zero_reg_stored: zrdata0=%h drdata0=%h zcnt=%0d, expected 0000 ffff 1", z_rd0, d_rd0, z_cnt);
      end
      idle();
   endtask

   task automatic test_hold();
      we_n = 1'b0; waddr = 3'd7; wdata = 16'h00FF;
      step();
      we_n = 1'b1;
      oe_n = 1'b0; raddr0 = 3'd7;
      step();
      tests++;
      if (d_rd0 !== 16'h00FF || d_rv !== 1'b1) begin
         fails++;
         $display("FAIL hold_setup: rdata0=%h rvalid=%b, expected 00ff 1", d_rd0, d_rv);
      end
      oe_n = 1'b1; raddr0 = 3'd4;
      we_n = 1'b0; waddr = 3'd4; wdata = 16'h4444;
      busy_addr = 'x;
      step();
      tests++;
      if (d_rd0 !== 16'h00FF || d_rv !== 1'b0 || d_cnt !== 4'd2) begin
         fails++;
         $display("FAIL hold: rdata0=%h rvalid=%b cnt=%0d, expected 00ff 0 2", d_rd0, d_rv, d_cnt);
      end
      we_n = 1'b1; waddr = 'x; wdata = 'x;
      oe_n = 1'b0;
      step();
      tests++;
      if (d_rd0 !== 16'h4444 || n_rd0 !== 16'h4444 || d_cnt !== 4'd2) begin
         fails++;
         $display("FAIL hold_write_landed: rdata0=%h nrdata0=%h cnt=%0d, expected 4444 4444 2", d_rd0, n_rd0, d_cnt);
      end
      idle();
      waddr = '0; wdata = '0; busy_addr = '0;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_scoreboard();
      test_zero_reg();
      test_hold();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
